// File: rtl/alu_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encoding
// and the add/subtract operation select values.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Purely combinational CW-bit adder slice: sum, carry out, and the carry
// into the slice MSB (needed for two's-complement overflow on the last chunk).
module chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb
);

    logic [CW:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + (CW+1)'(ci);
    assign s     = full[CW-1:0];
    assign co    = full[CW];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    assign c_msb = full[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

// File: rtl/serial_add_sub.sv
// Chunk-serial WL-bit adder/subtractor: processes CW bits per clock, LSB
// chunk first, and pulses Done when Addout/CO/OVF_F are valid.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter int WL = 32,
    parameter int CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Start,
    input  logic          Sub,
    input  logic          Signed,
    input  logic [WL-1:0] Addin1,
    input  logic [WL-1:0] Addin2,
    output logic [WL-1:0] Addout,
    output logic          CO,
    output logic          OVF_F,
    output logic          Busy,
    output logic          Done
);

    localparam int NCH   = WL / CW;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    state_t             state, state_nxt;
    logic [WL-1:0]      a_q, b_q;
    logic               sub_q, signed_q;
    logic [IDX_W-1:0]   idx;
    logic               carry;

    logic [CW-1:0]      a_chunk, b_chunk, sum_chunk;
    logic               co_chunk, c_msb_chunk;
    logic               accept, last_chunk;

    assign accept     = (state != RUN) && Start;
    assign last_chunk = (idx == IDX_W'(NCH - 1));

    // State register
    always_ff @(posedge CLK) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // (which would infer a latch).
        state_nxt = state;
        unique case (state)
            IDLE, DONE: state_nxt = Start ? RUN : IDLE;
            RUN:        state_nxt = last_chunk ? DONE : RUN;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

    always_comb begin
        a_chunk = a_q[int'(idx) * CW +: CW];
        b_chunk = (sub_q == OP_ADD) ? b_q[int'(idx) * CW +: CW]
                                    : ~b_q[int'(idx) * CW +: CW];
    end

    chunk_adder #(.CW(CW)) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry),
        .s     (sum_chunk),
        .co    (co_chunk),
        .c_msb (c_msb_chunk)
    );

    // Datapath: operand capture, chunk accumulation, final flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            signed_q <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            Addout   <= '0;
            CO       <= 1'b0;
            OVF_F    <= 1'b0;
        end else if (accept) begin
            a_q      <= Addin1;
            b_q      <= Addin2;
            sub_q    <= Sub;
            signed_q <= Signed;
            idx      <= '0;
            carry    <= (Sub == OP_SUB);
        end else if (state == RUN) begin
            Addout[int'(idx) * CW +: CW] <= sum_chunk;
            carry <= co_chunk;
            idx   <= idx + IDX_W'(1);
            if (last_chunk) begin
                CO <= co_chunk;
                // Unsigned subtract overflows on borrow, i.e. when no carry out.
                if (signed_q)   OVF_F <= c_msb_chunk ^ co_chunk;
                else if (sub_q) OVF_F <= ~co_chunk;
                else            OVF_F <= co_chunk;
            end
        end
    end

endmodule
